// File: rtl/reset_sequencer.sv
// Reset sequencer: drives a reset into a remote clock domain and confirms entry to and exit from
// reset through a synchronised acknowledge handshake, with an optional per-phase timeout.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_WIDTH = 16,
    parameter int TIMEOUT     = 1024,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ack_in,
    output logic rst_out,
    output logic busy,
    output logic done,
    output logic error
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic             TMO_EN     = (TIMEOUT > 0);

    // Saturating increment; holds once the limit is reached.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic [CNT_W-1:0] limit);
        logic [CNT_W-1:0] res;
        if (cnt == limit) begin
            res = cnt;
        end else begin
            res = cnt + CNT_ONE;
        end
        return res;
    endfunction

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       pulse_cnt_r;
    logic [CNT_W-1:0]       pulse_cnt_nxt_s;
    logic [CNT_W-1:0]       tmo_cnt_r;
    logic [CNT_W-1:0]       tmo_cnt_nxt_s;
    logic [SYNC_STAGES-1:0] ack_sync_r;
    logic                   ack_s;
    logic                   pulse_done_s;
    logic                   tmo_hit_s;
    logic                   rst_out_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   error_r;
    logic                   rst_out_nxt_s;
    logic                   busy_nxt_s;
    logic                   done_nxt_s;
    logic                   error_nxt_s;

    // Plain flop chain bringing the remote reset status into this clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign ack_s        = ack_sync_r[SYNC_STAGES-1];
    assign pulse_done_s = (pulse_cnt_r == PULSE_LAST);
    assign tmo_hit_s    = TMO_EN && (tmo_cnt_r == TMO_LAST);

    // Next-state, counter and output decode for the handshake sequence.
    always_comb begin
        state_nxt_s     = state_r;
        pulse_cnt_nxt_s = pulse_cnt_r;
        tmo_cnt_nxt_s   = tmo_cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    state_nxt_s     = ST_ASSERT;
                    pulse_cnt_nxt_s = CNT_ZERO;
                    tmo_cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                // A new request restarts the pulse, so it also blocks the exit this cycle.
                if (!req && pulse_done_s && ack_s) begin
                    state_nxt_s   = ST_RELEASE;
                    tmo_cnt_nxt_s = CNT_ZERO;
                end else if (tmo_hit_s) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    tmo_cnt_nxt_s = sat_inc(tmo_cnt_r, CNT_MAX);
                    if (req) begin
                        pulse_cnt_nxt_s = CNT_ZERO;
                    end else begin
                        pulse_cnt_nxt_s = sat_inc(pulse_cnt_r, PULSE_LAST);
                    end
                end
            end
            ST_RELEASE: begin
                if (req) begin
                    state_nxt_s     = ST_ASSERT;
                    pulse_cnt_nxt_s = CNT_ZERO;
                    tmo_cnt_nxt_s   = CNT_ZERO;
                end else if (!ack_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (tmo_hit_s) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    tmo_cnt_nxt_s = sat_inc(tmo_cnt_r, CNT_MAX);
                end
            end
            ST_ERROR: begin
                if (req) begin
                    state_nxt_s     = ST_ASSERT;
                    pulse_cnt_nxt_s = CNT_ZERO;
                    tmo_cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_ERROR;
                end
            end
            default: begin
                state_nxt_s     = ST_ASSERT;
                pulse_cnt_nxt_s = CNT_ZERO;
                tmo_cnt_nxt_s   = CNT_ZERO;
            end
        endcase

        rst_out_nxt_s = (state_nxt_s == ST_ASSERT);
        busy_nxt_s    = (state_nxt_s == ST_ASSERT) || (state_nxt_s == ST_RELEASE);
        done_nxt_s    = (state_r == ST_RELEASE) && (state_nxt_s == ST_IDLE);
        error_nxt_s   = (state_nxt_s == ST_ERROR);
    end

    // State, counters and registered outputs; reset lands in ASSERT so a sequence follows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_ASSERT;
            pulse_cnt_r <= CNT_ZERO;
            tmo_cnt_r   <= CNT_ZERO;
            rst_out_r   <= 1'b1;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pulse_cnt_r <= pulse_cnt_nxt_s;
            tmo_cnt_r   <= tmo_cnt_nxt_s;
            rst_out_r   <= rst_out_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            error_r     <= error_nxt_s;
        end
    end

    assign rst_out = rst_out_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign error   = error_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: each sequence ending (done pulse or error rise) is checked
// against the queued expectation of kind, rst_out high length and low tail before the event.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       ack_in;
    logic       rst_out;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] ack_mode = 2'd0;   // 0: loopback, 1: tied low, 2: tied high

    typedef struct {
        bit is_err;
        int hi;
        int tail;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    assign ack_in = (ack_mode == 2'd0) ? rst_out : (ack_mode == 2'd2);

    reset_sequencer #(
        .SYNC_STAGES(2),
        .PULSE_WIDTH(16),
        .TIMEOUT    (64),
        .CNT_W      (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .ack_in (ack_in),
        .rst_out(rst_out),
        .busy   (busy),
        .done   (done),
        .error  (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input bit is_err, input int hi, input int tail);
        exp_t e;
        e.is_err = is_err;
        e.hi     = hi;
        e.tail   = tail;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; req is sampled at the following edge (E0).
    task automatic pulse_req();
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d events pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: measures rst_out high run and low tail, pops an expectation per sequence end.
    initial begin
        int  run_hi;
        int  last_hi;
        int  tail;
        bit  prev_out;
        bit  err_prev;
        exp_t e;
        run_hi   = 0;
        last_hi  = 0;
        tail     = 0;
        prev_out = 1'b1;
        err_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run_hi   = 0;
                tail     = 0;
                prev_out = rst_out;
                err_prev = error;
            end else begin
                if (rst_out) begin
                    run_hi++;
                end else if (prev_out) begin
                    last_hi = run_hi;
                    run_hi  = 0;
                    tail    = 0;
                end else begin
                    tail++;
                end
                prev_out = rst_out;
                if (done && error) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL done_error_overlap: done=%0d error=%0d, expected not both", done, error);
                end
                if (done || (error && !err_prev)) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_event: done=%0d error=%0d hi=%0d tail=%0d, expected none",
                                 done, error, last_hi, tail);
                    end else begin
                        e = exp_q.pop_front();
                        if (error !== e.is_err || last_hi != e.hi || tail != e.tail) begin
                            n_fail++;
                            $display("FAIL seq_event: got err=%0d hi=%0d tail=%0d, expected err=%0d hi=%0d tail=%0d",
                                     error, last_hi, tail, e.is_err, e.hi, e.tail);
                        end
                    end
                end
                err_prev = error;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-on: reset held for five cycles with loopback.
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("por_rst_out", rst_out, 1);
        check("por_busy", busy, 1);
        check("por_done", done, 0);
        check("por_error", error, 0);
        @(posedge clk);
        #1;
        push(1'b0, 16, 3);
        rst = 1'b0;
        drain("por", 100);
        check("por_idle_done", done, 0);
        check("por_idle_busy", busy, 0);
        check("por_idle_rst_out", rst_out, 0);

        // Loopback request: 16-cycle pulse, done after E19.
        repeat (3) @(posedge clk);
        #1;
        push(1'b0, 16, 3);
        pulse_req();
        check("lb_busy", busy, 1);
        check("lb_rst_out", rst_out, 1);
        check("lb_error", error, 0);
        drain("loopback", 100);
        check("lb_idle_busy", busy, 0);

        // Request re-issued at E10 extends the pulse to 26 cycles.
        repeat (3) @(posedge clk);
        #1;
        push(1'b0, 26, 3);
        pulse_req();
        repeat (9) @(posedge clk);
        #1;
        pulse_req();
        drain("reissue", 100);

        // Acknowledge never arrives: timeout in ASSERT after 64 cycles.
        ack_mode = 2'd1;
        repeat (3) @(posedge clk);
        #1;
        push(1'b1, 64, 0);
        pulse_req();
        drain("tmo_assert", 150);
        check("tmo_error", error, 1);
        check("tmo_busy", busy, 0);
        check("tmo_rst_out", rst_out, 0);
        check("tmo_done", done, 0);
        repeat (5) @(posedge clk);
        #1;
        check("tmo_error_sticky", error, 1);
        ack_mode = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        push(1'b0, 16, 3);
        pulse_req();
        check("tmo_clear_error", error, 0);
        check("tmo_clear_busy", busy, 1);
        drain("tmo_recover", 100);

        // Acknowledge stuck high: timeout 64 cycles into RELEASE.
        ack_mode = 2'd2;
        #1;
        push(1'b1, 16, 64);
        pulse_req();
        drain("tmo_release", 200);
        check("stuck_error", error, 1);
        check("stuck_busy", busy, 0);
        ack_mode = 2'd0;
        repeat (5) @(posedge clk);
        #1;
        push(1'b0, 16, 3);
        pulse_req();
        drain("stuck_recover", 100);

        // One-cycle rst during RELEASE: asynchronous rst_out and a full rerun with one done.
        repeat (3) @(posedge clk);
        #1;
        push(1'b0, 16, 3);
        pulse_req();
        repeat (16) @(posedge clk);
        #1;
        check("rel_pre_rst_out", rst_out, 0);
        rst = 1'b1;
        #1;
        check("rel_async_rst_out", rst_out, 1);
        check("rel_async_busy", busy, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        drain("rst_rerun", 100);
        repeat (30) @(posedge clk);
        #1;
        check("final_rst_out", rst_out, 0);
        check("final_busy", busy, 0);
        check("final_error", error, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
